// File: rtl/rb_param_bank.sv
// Register bank between control unit and ALU. It has one write port fed by an 8-way source mux and
// two combinational ALU read ports with optional write-through. It also has a handshaked output latch
// and a sticky flag that records inc/dec wrap-around.
module rb_param_bank #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] InA,
  input  logic [DATA_W-1:0] InB,
  input  logic [DATA_W-1:0] CUconst,
  input  logic [DATA_W-1:0] ALUout,
  input  logic [2:0]        InMuxAdd,
  input  logic              WE,
  input  logic [ADDR_W-1:0] RegAdd,
  input  logic [ADDR_W-1:0] MovAdd,
  input  logic [ADDR_W-1:0] RdAddA,
  input  logic [ADDR_W-1:0] RdAddB,
  output logic [DATA_W-1:0] ALUinA,
  output logic [DATA_W-1:0] ALUinB,
  input  logic [ADDR_W-1:0] OutMuxAdd,
  input  logic              OutReq,
  input  logic              OutAck,
  output logic [DATA_W-1:0] Out,
  output logic              OutValid,
  output logic              WrapFlag,
  input  logic              FlagClr
);

  localparam logic [ADDR_W:0] REG_COUNT = NUM_REGS[ADDR_W:0];

  typedef enum logic {EMPTY, FULL} outState_t;

  function automatic logic isLegal(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < REG_COUNT;
  endfunction

  logic [DATA_W-1:0] regFile [NUM_REGS];
  logic [DATA_W-1:0] curVal;
  logic [DATA_W-1:0] movVal;
  logic [DATA_W-1:0] capVal;
  logic [DATA_W-1:0] writeData;
  logic              writeLegal;
  logic              wrapHit;
  outState_t         outState;
  logic [DATA_W-1:0] outData;
  logic              wrapReg;

  // Move, inc/dec and capture all see the contents stored before the edge.
  assign curVal     = isLegal(RegAdd)    ? regFile[RegAdd]    : '0;
  assign movVal     = isLegal(MovAdd)    ? regFile[MovAdd]    : '0;
  assign capVal     = isLegal(OutMuxAdd) ? regFile[OutMuxAdd] : '0;
  assign writeLegal = WE && isLegal(RegAdd);

  always_comb begin
    writeData = '0;
    case (InMuxAdd)
      3'd0:    writeData = InA;
      3'd1:    writeData = InB;
      3'd2:    writeData = CUconst;
      3'd3:    writeData = ALUout;
      3'd4:    writeData = movVal;
      3'd5:    writeData = curVal + 1'b1;
      3'd6:    writeData = curVal - 1'b1;
      default: writeData = '0;
    endcase
  end

  assign wrapHit = writeLegal &&
                   (((InMuxAdd == 3'd5) && (curVal == {DATA_W{1'b1}})) ||
                    ((InMuxAdd == 3'd6) && (curVal == '0)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regFile[i] <= '0;
    end else if (writeLegal) begin
      regFile[RegAdd] <= writeData;
    end
  end

  // Both read ports share one structure; forwarding is suppressed while reset is held.
  logic [1:0][ADDR_W-1:0] rdAdd;
  logic [1:0][DATA_W-1:0] aluIn;
  assign rdAdd[0] = RdAddA;
  assign rdAdd[1] = RdAddB;

  for (genvar gi = 0; gi < 2; gi++) begin : gReadPort
    logic forwardHit;
    assign forwardHit = (BYPASS != 0) && reset && writeLegal && (RegAdd == rdAdd[gi]);
    assign aluIn[gi]  = forwardHit ? writeData :
                        (isLegal(rdAdd[gi]) ? regFile[rdAdd[gi]] : '0);
  end

  assign ALUinA = aluIn[0];
  assign ALUinB = aluIn[1];

  // FULL never overwrites unconsumed data unless the consumer acks in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outState <= EMPTY;
      outData  <= '0;
    end else begin
      case (outState)
        EMPTY: begin
          if (OutReq) begin
            outData  <= capVal;
            outState <= FULL;
          end
        end
        FULL: begin
          if (OutAck) begin
            if (OutReq) outData <= capVal;
            else        outState <= EMPTY;
          end
        end
        default: outState <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       wrapReg <= 1'b0;
    else if (wrapHit) wrapReg <= 1'b1;
    else if (FlagClr) wrapReg <= 1'b0;
  end

  assign Out      = outData;
  assign OutValid = (outState == FULL);
  assign WrapFlag = wrapReg;

endmodule
